// File: rtl/vote_collector.sv
// Ballot initiator for a small majority-vote scheme: requests a vote from every voter,
// collects req/ack answers until all respond or the timer expires, then publishes a held tally.
module vote_collector #(
    parameter int N_VOTERS  = 4,
    parameter int THRESHOLD = 3,
    parameter int TIMEOUT   = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    output logic [N_VOTERS-1:0]              req,
    input  logic [N_VOTERS-1:0]              ack,
    input  logic [N_VOTERS-1:0]              vote,
    output logic                             busy,
    output logic                             done,
    output logic                             pass,
    output logic [$clog2(N_VOTERS+1)-1:0]    yes_count,
    output logic [N_VOTERS-1:0]              ack_mask,
    output logic                             timed_out
);

    localparam int CW = $clog2(N_VOTERS + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] PASS_MIN   = CW'(THRESHOLD);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DECIDE
    } state_t;

    state_t              state_q, state_d;
    logic [N_VOTERS-1:0] req_q, req_d;
    logic [N_VOTERS-1:0] votes_q, votes_d;
    logic [N_VOTERS-1:0] got_q, got_d;
    logic [N_VOTERS-1:0] mask_q, mask_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [CW-1:0]       yes_q, yes_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                to_q, to_d;
    logic [N_VOTERS-1:0] hit;

    function automatic logic [CW-1:0] popcount(input logic [N_VOTERS-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < N_VOTERS; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    // Only acks answering an outstanding request count, so duplicates and strays are dropped.
    assign hit = req_q & ack;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        votes_d = votes_q;
        got_d   = got_q;
        mask_d  = mask_q;
        timer_d = timer_q;
        yes_d   = yes_q;
        pass_d  = pass_q;
        to_d    = to_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COLLECT;
                    req_d   = '1;
                    timer_d = '0;
                    votes_d = '0;
                    got_d   = '0;
                end
            end
            COLLECT: begin
                votes_d = votes_q | (hit & vote);
                got_d   = got_q | hit;
                req_d   = req_q & ~hit;
                if (timer_q != TIMER_LAST) begin
                    timer_d = timer_q + 1'b1;
                end
                if ((&got_d) || (timer_q == TIMER_LAST)) begin
                    state_d = DECIDE;
                end
            end
            DECIDE: begin
                yes_d   = popcount(votes_q & got_q);
                pass_d  = (yes_d >= PASS_MIN);
                mask_d  = got_q;
                to_d    = ~(&got_q);
                done_d  = 1'b1;
                req_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = '0;
            end
        endcase
    end

    // Results live in separate registers so a new ballot leaves the previous outcome visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= '0;
            votes_q <= '0;
            got_q   <= '0;
            mask_q  <= '0;
            timer_q <= '0;
            yes_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            votes_q <= votes_d;
            got_q   <= got_d;
            mask_q  <= mask_d;
            timer_q <= timer_d;
            yes_q   <= yes_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            to_q    <= to_d;
        end
    end

    assign req       = req_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign pass      = pass_q;
    assign yes_count = yes_q;
    assign ack_mask  = mask_q;
    assign timed_out = to_q;

endmodule

// File: tb/tb_vote_collector.sv
// Self-checking bench for vote_collector: table-driven ballots with a scoreboard of
// expected results popped on each done pulse, plus hand-written restart and reset sequences.
module tb_vote_collector;

    localparam int NV    = 4;
    localparam int TH    = 3;
    localparam int TO    = 16;
    localparam int NEVER = 255;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NV-1:0] req;
    logic [NV-1:0] ack;
    logic [NV-1:0] vote;
    logic          busy;
    logic          done;
    logic          pass;
    logic [2:0]    yes_count;
    logic [NV-1:0] ack_mask;
    logic          timed_out;

    int checks    = 0;
    int failures  = 0;
    int edgeCount = 0;

    typedef struct {
        string          name;
        logic [3:0][7:0] ackAt;
        logic [3:0]     votes;
        int             dupVoter;
        int             dupAt;
        logic           dupVote;
        int             startAt;
        bit             preAck;
        logic [2:0]     expYes;
        logic           expPass;
        logic [3:0]     expMask;
        logic           expTo;
        int             lat;
    } vec_t;

    typedef struct {
        string      name;
        logic [2:0] yes;
        logic       pass;
        logic [3:0] mask;
        logic       to;
        int         edgeAt;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[8];

    vote_collector #(
        .N_VOTERS (NV),
        .THRESHOLD(TH),
        .TIMEOUT  (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .req      (req),
        .ack      (ack),
        .vote     (vote),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .yes_count(yes_count),
        .ack_mask (ack_mask),
        .timed_out(timed_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCount <= edgeCount + 1;

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input int a0, input int a1, input int a2,
                                input int a3, input logic [3:0] v, input int dv, input int da,
                                input logic dvote, input int sa, input bit pre,
                                input int y, input logic p, input logic [3:0] m,
                                input logic t, input int lat);
        vec_t r;
        r.name     = n;
        r.ackAt[0] = 8'(a0);
        r.ackAt[1] = 8'(a1);
        r.ackAt[2] = 8'(a2);
        r.ackAt[3] = 8'(a3);
        r.votes    = v;
        r.dupVoter = dv;
        r.dupAt    = da;
        r.dupVote  = dvote;
        r.startAt  = sa;
        r.preAck   = pre;
        r.expYes   = 3'(y);
        r.expPass  = p;
        r.expMask  = m;
        r.expTo    = t;
        r.lat      = lat;
        return r;
    endfunction

    task automatic pushExp(input string n, input int y, input logic p, input logic [3:0] m,
                           input logic t, input int edgeAt);
        exp_t e;
        e.name   = n;
        e.yes    = 3'(y);
        e.pass   = p;
        e.mask   = m;
        e.to     = t;
        e.edgeAt = edgeAt;
        sbq.push_back(e);
    endtask

    // Each done pulse must match the oldest outstanding ballot, including the edge it lands on.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sbq.size() == 0) begin
                checkOutput("unexpectedDone", 32'(edgeCount), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                checkOutput({e.name, ".yes_count"}, 32'(yes_count), 32'(e.yes));
                checkOutput({e.name, ".pass"}, 32'(pass), 32'(e.pass));
                checkOutput({e.name, ".ack_mask"}, 32'(ack_mask), 32'(e.mask));
                checkOutput({e.name, ".timed_out"}, 32'(timed_out), 32'(e.to));
                checkOutput({e.name, ".doneEdge"}, 32'(edgeCount), 32'(e.edgeAt));
            end
        end
    end

    task automatic applyStimulus(input vec_t v);
        int         decEdge;
        logic [3:0] expReq;
        decEdge = v.lat - 1;
        if (v.preAck) begin
            ack  = '1;
            vote = '1;
            repeat (2) begin
                @(posedge clk); #1;
                checkOutput({v.name, ".preAckBusy"}, 32'(busy), 32'd0);
                checkOutput({v.name, ".preAckReq"}, 32'(req), 32'd0);
            end
            ack  = '0;
            vote = '0;
        end
        start = 1'b1;
        pushExp(v.name, int'(v.expYes), v.expPass, v.expMask, v.expTo, edgeCount + 1 + v.lat);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < TO + 4; k++) begin
            for (int i = 0; i < NV; i++) begin
                expReq[i] = (k <= decEdge) &&
                            !((int'(v.ackAt[i]) != NEVER) && (int'(v.ackAt[i]) + 1 <= k));
            end
            checkOutput($sformatf("%s.req@%0d", v.name, k), 32'(req), 32'(expReq));
            checkOutput($sformatf("%s.busy@%0d", v.name, k), 32'(busy), 32'(k <= decEdge));
            ack  = '0;
            vote = '0;
            for (int i = 0; i < NV; i++) begin
                if (int'(v.ackAt[i]) == k) begin
                    ack[i]  = 1'b1;
                    vote[i] = v.votes[i];
                end
            end
            if (v.dupAt == k) begin
                ack[v.dupVoter]  = 1'b1;
                vote[v.dupVoter] = v.dupVote;
            end
            start = (v.startAt == k);
            @(posedge clk); #1;
        end
        ack   = '0;
        vote  = '0;
        start = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        ack   = '0;
        vote  = '0;

        //                 name         a0     a1     a2     a3     votes    dv  da     dvote sa     pre  y  p     mask     to    lat
        vecs[0] = mk("allFirst",     0,     0,     0,     0,     4'b1110, 0, NEVER, 1'b0, NEVER, 0,   3, 1'b1, 4'b1111, 1'b0, 2);
        vecs[1] = mk("staggered",    2,     4,     5,     7,     4'b1101, 0, NEVER, 1'b0, 3,     0,   3, 1'b1, 4'b1111, 1'b0, 9);
        vecs[2] = mk("v3Silent",     1,     2,     3,     NEVER, 4'b0011, 0, NEVER, 1'b0, NEVER, 0,   2, 1'b0, 4'b0111, 1'b1, 17);
        vecs[3] = mk("dupAck",       6,     1,     6,     6,     4'b0110, 1, 3,     1'b0, NEVER, 1,   2, 1'b0, 4'b1111, 1'b0, 8);
        vecs[4] = mk("allYes",       0,     0,     0,     0,     4'b1111, 0, NEVER, 1'b0, NEVER, 0,   4, 1'b1, 4'b1111, 1'b0, 2);
        vecs[5] = mk("allNo",        0,     1,     2,     3,     4'b0000, 0, NEVER, 1'b0, NEVER, 0,   0, 1'b0, 4'b1111, 1'b0, 5);
        vecs[6] = mk("expiryAck",    0,     0,     0,     15,    4'b1000, 0, NEVER, 1'b0, NEVER, 0,   1, 1'b0, 4'b1111, 1'b0, 17);
        vecs[7] = mk("lateAck",      0,     0,     0,     16,    4'b1111, 0, NEVER, 1'b0, NEVER, 0,   3, 1'b1, 4'b0111, 1'b1, 17);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.req", 32'(req), 32'd0);
        checkOutput("rst.busy", 32'(busy), 32'd0);
        checkOutput("rst.done", 32'(done), 32'd0);
        checkOutput("rst.pass", 32'(pass), 32'd0);
        checkOutput("rst.yes_count", 32'(yes_count), 32'd0);
        checkOutput("rst.ack_mask", 32'(ack_mask), 32'd0);
        checkOutput("rst.timed_out", 32'(timed_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int n = 0; n < 8; n++) begin
            applyStimulus(vecs[n]);
        end

        // Reset in the middle of a ballot: everything clears at once and no done follows.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        checkOutput("midRst.reqBefore", 32'(req), 32'hF);
        #1 rst = 1'b1;
        #1;
        checkOutput("midRst.req", 32'(req), 32'd0);
        checkOutput("midRst.busy", 32'(busy), 32'd0);
        checkOutput("midRst.done", 32'(done), 32'd0);
        checkOutput("midRst.pass", 32'(pass), 32'd0);
        checkOutput("midRst.yes_count", 32'(yes_count), 32'd0);
        checkOutput("midRst.ack_mask", 32'(ack_mask), 32'd0);
        checkOutput("midRst.timed_out", 32'(timed_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        checkOutput("postRst.busy", 32'(busy), 32'd0);

        // Ballot A, then ballot B started in A's done cycle; A's results hold while B collects.
        start = 1'b1;
        pushExp("restartA", 4, 1'b1, 4'b1111, 1'b0, edgeCount + 1 + 2);
        @(posedge clk); #1;
        start = 1'b0;
        ack   = '1;
        vote  = '1;
        @(posedge clk); #1;
        ack  = '0;
        vote = '0;
        @(posedge clk); #1;
        checkOutput("restartA.doneCycle", 32'(done), 32'd1);
        start = 1'b1;
        pushExp("restartB", 0, 1'b0, 4'b1111, 1'b0, edgeCount + 1 + 5);
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("restartB.busy", 32'(busy), 32'd1);
        for (int k = 0; k < 8; k++) begin
            if (k == 2) begin
                checkOutput("restartB.heldYes", 32'(yes_count), 32'd4);
                checkOutput("restartB.heldPass", 32'(pass), 32'd1);
            end
            ack  = (k < 4) ? 4'(1 << k) : 4'b0000;
            vote = '0;
            @(posedge clk); #1;
        end
        ack = '0;

        repeat (4) @(posedge clk);
        #1;
        checkOutput("scoreboardEmpty", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
